// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared constants for the SRAM-backed FIFO controller.
package sram_fifo_ctrl_pkg;

    // Number of entries in the show-ahead output buffer in front of the SRAM.
    localparam int OB_DEPTH = 2;

    // Occupancy of the output buffer, 0..OB_DEPTH.
    typedef logic [1:0] ob_level_t;

endpackage : sram_fifo_ctrl_pkg

// File: rtl/sram_sync_1r1w.sv
// Simple dual-port synchronous SRAM: one write port, one registered read port.
// A read and a write to the same address on the same edge returns the old data.
module sram_sync_1r1w #(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 256,
    localparam int W_ADDR = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [W_ADDR-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              ren,
    input  logic [W_ADDR-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write and registered read; the read samples the array before this edge's write lands.
    // NOTE: the array has no reset on purpose; a reset would turn the macro into flops.
    // NOTE: non-blocking assignments are what give the old-data read on address collision.
    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        if (ren) rdata <= mem[raddr];
    end

endmodule : sram_sync_1r1w

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO using one SRAM for storage, with a 2-entry prefetch buffer that
// hides the SRAM read latency so out_data is show-ahead and pops can run every cycle.
module sram_fifo_ctrl
    import sram_fifo_ctrl_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int DEPTH   = 256,
    localparam int W_ADDR  = $clog2(DEPTH),
    localparam int W_LEVEL = $clog2(DEPTH + 3)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_LEVEL-1:0] level
);

    localparam logic [W_ADDR:0]    MEM_FULL  = (W_ADDR + 1)'(DEPTH);
    localparam logic [W_LEVEL-1:0] LEVEL_MAX = W_LEVEL'(DEPTH + 2);

    logic [W_ADDR-1:0] wptr;
    logic [W_ADDR-1:0] rptr;
    logic [W_ADDR:0]   mem_level;
    logic              rd_inflight;
    ob_level_t         ob_level;
    logic [WIDTH-1:0]  ob_head;
    logic [WIDTH-1:0]  ob_tail;
    logic [WIDTH-1:0]  rdata;

    logic              push;
    logic              pop;
    logic              ren;
    logic              capture;
    logic [2:0]        ob_claim;

    // Outputs come from registered state only, so there is no comb path from out_ready.
    assign in_ready  = (mem_level != MEM_FULL);
    assign out_valid = (ob_level != '0);
    assign out_data  = ob_head;
    assign level     = W_LEVEL'(mem_level) + W_LEVEL'(rd_inflight) + W_LEVEL'(ob_level);

    // Handshakes and read issue; a read is only launched when its data is sure to find a slot.
    // NOTE: every output here is assigned on every path, so no latch is inferred.
    always_comb begin
        push     = in_valid && in_ready && !flush;
        pop      = out_valid && out_ready && !flush;
        capture  = rd_inflight && !flush;
        ob_claim = {1'b0, ob_level} + {2'b00, rd_inflight} - {2'b00, pop};
        ren      = !flush && (mem_level != '0) && (ob_claim < 3'(OB_DEPTH));
    end

    sram_sync_1r1w #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .wen   (push),
        .waddr (wptr),
        .wdata (in_data),
        .ren   (ren),
        .raddr (rptr),
        .rdata (rdata)
    );

    // Pointers, SRAM occupancy and the read-in-flight marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            mem_level   <= '0;
            rd_inflight <= 1'b0;
        end else if (flush) begin
            wptr        <= '0;
            rptr        <= '0;
            mem_level   <= '0;
            rd_inflight <= 1'b0;
        end else begin
            if (push) wptr <= wptr + W_ADDR'(1);
            if (ren)  rptr <= rptr + W_ADDR'(1);
            case ({push, ren})
                2'b10:   mem_level <= mem_level + (W_ADDR + 1)'(1);
                2'b01:   mem_level <= mem_level - (W_ADDR + 1)'(1);
                default: mem_level <= mem_level;
            endcase
            rd_inflight <= ren;
        end
    end

    // Two-entry output buffer: returning SRAM data fills head or tail, a pop shifts tail to head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_head  <= '0;
            ob_tail  <= '0;
            ob_level <= '0;
        end else if (flush) begin
            ob_head  <= '0;
            ob_tail  <= '0;
            ob_level <= '0;
        end else begin
            case ({capture, pop})
                2'b11: begin
                    if (ob_level == 2'd1) begin
                        ob_head <= rdata;
                    end else begin
                        ob_head <= ob_tail;
                        ob_tail <= rdata;
                    end
                end
                2'b10: begin
                    if (ob_level == 2'd0) ob_head <= rdata;
                    else                  ob_tail <= rdata;
                    ob_level <= ob_level + 2'd1;
                end
                2'b01: begin
                    if (ob_level == 2'd2) ob_head <= ob_tail;
                    ob_level <= ob_level - 2'd1;
                end
                default: ob_level <= ob_level;
            endcase
        end
    end

    // Protocol and occupancy invariants.
    ap_push_needs_ready : assert property (@(posedge clk) disable iff (!rst_n)
        push |-> in_ready);
    ap_nontransparent   : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && ren && (wptr == rptr)));
    ap_level_max        : assert property (@(posedge clk) disable iff (!rst_n)
        level <= LEVEL_MAX);
    ap_ob_level_max     : assert property (@(posedge clk) disable iff (!rst_n)
        ob_level <= ob_level_t'(OB_DEPTH));

endmodule : sram_fifo_ctrl

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: a DEPTH=8 instance runs directed and streaming scenarios,
// a DEPTH=4 instance runs random traffic with occasional flushes. Queues hold the
// expected output order; monitors on the falling edge compare and retire entries.
module tb_sram_fifo_ctrl;

    localparam int WIDTH = 16;
    localparam int D8    = 8;
    localparam int D4    = 4;
    localparam int WL8   = $clog2(D8 + 3);
    localparam int WL4   = $clog2(D4 + 3);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst8_n, flush8, in_valid8, in_ready8, out_valid8, out_ready8;
    logic [WIDTH-1:0] in_data8, out_data8;
    logic [WL8-1:0]   level8;

    logic             rst4_n, flush4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [WIDTH-1:0] in_data4, out_data4;
    logic [WL4-1:0]   level4;

    sram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(D8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .flush(flush8),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
        .level(level8)
    );

    sram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(D4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .flush(flush4),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .level(level4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected contents of each FIFO, oldest first.
    logic [WIDTH-1:0] q8[$];
    logic [WIDTH-1:0] q4[$];
    int               pushes4 = 0;
    bit               done4   = 1'b0;

    // Scoreboard monitor for the DEPTH=8 instance.
    always @(negedge clk) begin
        if (!rst8_n) begin
            q8.delete();
        end else begin
            check("level8", 32'(level8), 32'(q8.size()));
            if (q8.size() < D8)      check("in_ready8_space", 32'(in_ready8), 32'd1);
            if (q8.size() >= D8 + 2) check("in_ready8_full", 32'(in_ready8), 32'd0);
            if (out_valid8) begin
                if (q8.size() == 0) check("out_valid8_empty", 32'(out_valid8), 32'd0);
                else                check("out_data8", 32'(out_data8), 32'(q8[0]));
            end
            if (flush8) begin
                q8.delete();
            end else begin
                if (out_valid8 && out_ready8 && q8.size() != 0) void'(q8.pop_front());
                if (in_valid8 && in_ready8) q8.push_back(in_data8);
            end
        end
    end

    // Scoreboard monitor for the DEPTH=4 instance.
    always @(negedge clk) begin
        if (!rst4_n) begin
            q4.delete();
        end else begin
            check("level4", 32'(level4), 32'(q4.size()));
            if (q4.size() < D4)      check("in_ready4_space", 32'(in_ready4), 32'd1);
            if (q4.size() >= D4 + 2) check("in_ready4_full", 32'(in_ready4), 32'd0);
            if (out_valid4) begin
                if (q4.size() == 0) check("out_valid4_empty", 32'(out_valid4), 32'd0);
                else                check("out_data4", 32'(out_data4), 32'(q4[0]));
            end
            if (flush4) begin
                q4.delete();
            end else begin
                if (out_valid4 && out_ready4 && q4.size() != 0) void'(q4.pop_front());
                if (in_valid4 && in_ready4) begin
                    q4.push_back(in_data4);
                    pushes4++;
                end
            end
        end
    end

    // Drain the DEPTH=8 FIFO with a bounded wait; returns the number of pops seen.
    task automatic drain8(input string name, output int pops);
        pops = 0;
        @(posedge clk); #1;
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        for (int c = 0; c < 40 && level8 != '0; c++) begin
            @(negedge clk);
            if (out_valid8 && out_ready8) pops++;
        end
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        @(negedge clk);
        check({name, "_level"}, 32'(level8), 32'd0);
        check({name, "_out_valid"}, 32'(out_valid8), 32'd0);
    endtask

    // Random traffic on the DEPTH=4 instance: pointers wrap many times, full and empty are hit often.
    initial begin
        rst4_n = 1'b0; flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; in_data4 = '0;
        repeat (2) @(posedge clk);
        #1 rst4_n = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            in_valid4  = 1'($urandom_range(0, 1));
            out_ready4 = 1'($urandom_range(0, 1));
            in_data4   = 16'($urandom);
            flush4     = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        in_valid4 = 1'b0; flush4 = 1'b0; out_ready4 = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rand4_drained_level", 32'(level4), 32'd0);
        check("rand4_drained_valid", 32'(out_valid4), 32'd0);
        check("rand4_enough_pushes", 32'(pushes4 > 500), 32'd1);
        done4 = 1'b1;
    end

    // Directed and streaming scenarios on the DEPTH=8 instance.
    initial begin
        int accepted;
        int pops;
        int lvl_ref;

        rst8_n = 1'b0; flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; in_data8 = '0;
        repeat (2) @(posedge clk);
        #1 rst8_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_level", 32'(level8), 32'd0);
        check("rst_in_ready", 32'(in_ready8), 32'd1);
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_out_data", 32'(out_data8), 32'd0);

        // First-word latency: push in cycle 0, level 1 in cycle 1, output in cycle 3.
        @(posedge clk); #1;
        in_valid8 = 1'b1; in_data8 = 16'h00A1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        check("lat_level_c1", 32'(level8), 32'd1);
        check("lat_valid_c1", 32'(out_valid8), 32'd0);
        @(negedge clk);
        check("lat_valid_c2", 32'(out_valid8), 32'd0);
        @(negedge clk);
        check("lat_valid_c3", 32'(out_valid8), 32'd1);
        check("lat_data_c3", 32'(out_data8), 32'h00A1);
        drain8("lat_drain", pops);
        check("lat_pops", 32'(pops), 32'd1);

        // Fill with the consumer stalled: 8 in SRAM plus 2 in the output buffer.
        accepted = 0;
        @(posedge clk); #1;
        in_valid8 = 1'b1; in_data8 = 16'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_valid8 && in_ready8) accepted++;
            @(posedge clk); #1;
            in_data8  = 16'(accepted);
            in_valid8 = (accepted < 12);
        end
        @(negedge clk);
        check("fill_accepted", 32'(accepted), 32'd10);
        check("fill_in_ready", 32'(in_ready8), 32'd0);
        check("fill_level", 32'(level8), 32'd10);
        drain8("fill_drain", pops);
        check("fill_pops", 32'(pops), 32'd10);

        // Streaming at full rate.
        pops = 0;
        lvl_ref = 0;
        @(posedge clk); #1;
        in_valid8 = 1'b1; out_ready8 = 1'b1; in_data8 = 16'($urandom);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (out_valid8 && out_ready8) pops++;
            if (c == 20) lvl_ref = int'(level8);
            if (c > 20)  check("stream_level_const", 32'(level8), 32'(lvl_ref));
            @(posedge clk); #1;
            in_data8 = 16'($urandom);
        end
        check("stream_throughput", 32'(pops >= 997), 32'd1);
        drain8("stream_drain", pops);

        // Flush on a cycle where a read would issue: buffer full, SRAM holds 3, pop requested.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid8 = 1'b1; in_data8 = 16'(16'h0100 + i);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        check("flush_pre_level", 32'(level8), 32'd5);
        check("flush_pre_head", 32'(out_data8), 32'h0100);
        @(posedge clk); #1;
        flush8 = 1'b1; out_ready8 = 1'b1; in_valid8 = 1'b1; in_data8 = 16'h0077;
        @(posedge clk); #1;
        flush8 = 1'b0; out_ready8 = 1'b0; in_valid8 = 1'b0;
        @(negedge clk);
        check("flush_level", 32'(level8), 32'd0);
        check("flush_out_valid", 32'(out_valid8), 32'd0);
        check("flush_out_data", 32'(out_data8), 32'd0);
        @(posedge clk); #1;
        in_valid8 = 1'b1; in_data8 = 16'h0055;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("flush_restart_c2", 32'(out_valid8), 32'd0);
        @(negedge clk);
        check("flush_restart_valid", 32'(out_valid8), 32'd1);
        check("flush_restart_data", 32'(out_data8), 32'h0055);
        drain8("flush_drain", pops);
        check("flush_drain_pops", 32'(pops), 32'd1);

        // Flush while a read is in flight: the returning word must be dropped.
        @(posedge clk); #1;
        in_valid8 = 1'b1; in_data8 = 16'h0066;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        flush8 = 1'b1;
        @(posedge clk); #1;
        flush8 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("inflight_flush_valid", 32'(out_valid8), 32'd0);
            check("inflight_flush_level", 32'(level8), 32'd0);
        end

        // Asynchronous reset in the middle of a stream.
        @(posedge clk); #1;
        in_valid8 = 1'b1; out_ready8 = 1'b1; in_data8 = 16'($urandom);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_data8 = 16'($urandom);
        end
        @(posedge clk); #2;
        rst8_n = 1'b0;
        #1;
        check("arst_level", 32'(level8), 32'd0);
        check("arst_out_valid", 32'(out_valid8), 32'd0);
        check("arst_in_ready", 32'(in_ready8), 32'd1);
        check("arst_out_data", 32'(out_data8), 32'd0);
        @(posedge clk); #1;
        rst8_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            in_data8 = 16'($urandom);
        end
        drain8("arst_drain", pops);
        check("arst_restart_pops", 32'(pops > 0), 32'd1);

        // Wait for the random-traffic run on the small instance, bounded.
        for (int c = 0; c < 10000 && !done4; c++) @(posedge clk);
        check("rand4_completed", 32'(done4), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sram_fifo_ctrl
